// File: rtl/wb_spi_byte_if.sv
// Wishbone lane between the USB-ACM bridge (master) and the SPI byte engine (slave).
interface wb_spi_byte_if;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    modport master (
        output wb_addr, wb_wdata, wb_we, wb_cyc,
        input  wb_rdata, wb_ack
    );

    modport slave (
        input  wb_addr, wb_wdata, wb_we, wb_cyc,
        output wb_rdata, wb_ack
    );
endinterface

// File: rtl/wb_spi_byte.sv
// Wishbone-controlled byte-wide SPI master (mode 0) with SCK divider, manual CS and overrun flag.
// Define WBSPI_LSB_FIRST_EN for LSB-first shifting; default build is MSB first.
module wb_spi_byte #(
    parameter logic [7:0] DIV_RST = 8'd3
) (
    input  logic          clk,
    input  logic          rst,
    wb_spi_byte_if.slave  wb,
    output logic          spi_sck,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output logic          spi_cs_n
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

    state_t      state, state_nx;
    logic [7:0]  div, cnt, tx_sh, rx_sh, rx_byte;
    logic [2:0]  bit_cnt;
    logic        cs, overrun, busy, ack, sck;
    logic        wr_csr, wr_data, start, sample, shift, done;
    logic        unused_wdata;

    assign busy     = (state != S_IDLE);
    assign wr_csr   = ack & wb.wb_we & (wb.wb_addr == 2'd0);
    assign wr_data  = ack & wb.wb_we & (wb.wb_addr == 2'd1);
    assign wb.wb_ack = ack;
    assign spi_sck  = sck;
    assign spi_cs_n = ~cs;
    assign unused_wdata = ^{wb.wb_wdata[31], wb.wb_wdata[29:24], wb.wb_wdata[15:8]};

`ifdef WBSPI_LSB_FIRST_EN
    assign spi_mosi = tx_sh[0];
`else
    assign spi_mosi = tx_sh[7];
`endif

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        sample   = 1'b0;
        shift    = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_data) begin
                    start    = 1'b1;
                    state_nx = S_LO;
                end
            end
            S_LO: begin
                if (cnt == 8'd0) begin
                    sample   = 1'b1;
                    state_nx = S_HI;
                end
            end
            S_HI: begin
                if (cnt == 8'd0) begin
                    if (bit_cnt == 3'd7) begin
                        done     = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        shift    = 1'b1;
                        state_nx = S_LO;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack     <= 1'b0;
            div     <= DIV_RST;
            cs      <= 1'b0;
            overrun <= 1'b0;
            cnt     <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_byte <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
        end else begin
            ack <= wb.wb_cyc & ~ack;
            sck <= (state_nx == S_HI);

            if (wr_csr) begin
                div <= wb.wb_wdata[23:16];
                cs  <= wb.wb_wdata[0];
                if (wb.wb_wdata[30]) overrun <= 1'b0;
            end
            if (wr_data && busy) overrun <= 1'b1;

            // Reload picks up the live div, so a mid-transfer CSR write lands at the next phase.
            if (start || sample || shift) cnt <= div;
            else if (busy)                cnt <= cnt - 8'd1;

            if (start) begin
                tx_sh   <= wb.wb_wdata[7:0];
                bit_cnt <= '0;
            end
            if (sample) begin
`ifdef WBSPI_LSB_FIRST_EN
                rx_sh <= {spi_miso, rx_sh[7:1]};
`else
                rx_sh <= {rx_sh[6:0], spi_miso};
`endif
            end
            if (shift) begin
`ifdef WBSPI_LSB_FIRST_EN
                tx_sh <= {1'b0, tx_sh[7:1]};
`else
                tx_sh <= {tx_sh[6:0], 1'b0};
`endif
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (done) rx_byte <= rx_sh;
        end
    end

    always_comb begin
        wb.wb_rdata = '0;
        if (ack) begin
            case (wb.wb_addr)
                2'd0:    wb.wb_rdata = {busy, overrun, 6'b0, div, 15'b0, cs};
                2'd1:    wb.wb_rdata = {busy, 23'b0, rx_byte};
                default: wb.wb_rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/wb_spi_byte.md
# wb_spi_byte

Wishbone slave that runs byte-wide SPI master transfers (mode 0) under host control. It sits directly downstream of the USB-ACM Wishbone bridge on one `wb_cyc` lane, so the host PC can drive an external SPI flash or peripheral over the CDC link. It is a single clock domain (`clk`), with a programmable SCK divider, manual chip-select, a busy flag and a sticky overrun flag.

## Interface
Parameters:
- `DIV_RST`, default 3: reset value of the SCK divider field (8 bits).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_addr`  in  2  register select; the bridge's low address bits.
- `wb_wdata`  in  32  write data.
- `wb_rdata`  out  32  read data; forced to 0 whenever `wb_ack`=0, so it can be OR-muxed.
- `wb_we`  in  1  write enable.
- `wb_cyc`  in  1  cycle strobe for this slave's lane.
- `wb_ack`  out  1  single-cycle acknowledge.
- `spi_sck`  out  1  SPI clock. Idle level is low.
- `spi_mosi`  out  1  SPI data out.
- `spi_miso`  in  1  SPI data in. Already synchronous to `clk`; it is not resynchronised.
- `spi_cs_n`  out  1  chip select, active low, under software control.

## Operation
Register map, by `wb_addr`:
- 0 CSR
  - R: [31] busy, [30] overrun, [23:16] div, [0] cs.
  - W: [23:16] div, [0] cs (1 asserts `spi_cs_n`=0).
  - W: writing [30]=1 clears overrun.
- 1 DATA
  - W: [7:0] starts an 8-bit transfer if idle.
  - R: [31] busy, [7:0] last received byte.
- 2, 3: reads return 0; writes are acked and ignored.

Bus behaviour:
- `wb_ack` is a register set to `wb_cyc & ~wb_ack`. Every access is acked exactly one cycle after `wb_cyc` rises, and never two cycles in a row.
- The write side effect occurs on the ack cycle.

Transfer state machine:
- IDLE: `spi_sck`=0.
  - A DATA write loads the shift register, sets busy, and drives `spi_mosi` with the first data bit.
  - Transition to LO with the half-period counter `cnt`=div.
- LO: `spi_sck`=0. On `cnt`=0, go to HI with `cnt`=div and sample `spi_miso` into the receive shift register.
- HI: `spi_sck`=1. On `cnt`=0:
  - If the bit counter is 7, go to IDLE. Clear busy. Latch the RX byte into DATA[7:0].
  - Otherwise go to LO, shift, and present the next bit on `spi_mosi`.
- The bit counter is 3 bits, increments on each HI→LO transition, and resets to 0 when a transfer starts.

Boundary conditions:
- DATA write while busy: the write is dropped, overrun is set, and the ongoing transfer is unaffected.
- CSR write while busy:
  - cs updates immediately. Mid-transfer deselect is the host's responsibility.
  - div takes effect at the next reload of `cnt`.
- DATA read while busy returns the previous RX byte with bit 31 = 1.
- div = 0 gives the fastest rate: SCK = clk/2.
- Reset mid-transfer: the FSM returns to IDLE with `spi_sck`=0, and `spi_cs_n`=1 is asserted asynchronously.

## Timing
Reset values of outputs and registers:
- `wb_ack`=0, `wb_rdata`=0
- `spi_sck`=0, `spi_mosi`=0, `spi_cs_n`=1
- div=`DIV_RST`, busy=0, overrun=0, RX byte=0

Latencies:
- Bus: 1 cycle from `wb_cyc` to `wb_ack`.
- SCK half-period: (div+1) clk cycles.
- Transfer: the first rising SCK edge comes (div+1) cycles after the ack cycle. busy is high for 16·(div+1) cycles, ending on the cycle the final HI phase expires.
- MOSI changes only while SCK is low. MISO is sampled on the cycle SCK goes high.

## Configuration
- `WBSPI_LSB_FIRST_EN` defined:
  - Bits are shifted LSB first.
  - TX bit 0 goes out first.
  - The first received bit lands in RX[0].
- Undefined (default): MSB first. TX bit 7 goes out first and the first received bit lands in RX[7].
- The register map and timing are identical in both builds.

## Test plan
- Reset release → read CSR returns 0x0003_0000 (`DIV_RST`=3); `spi_cs_n`=1; `spi_sck`=0.
- Write CSR = 0x0000_0001, then DATA = 0xA5, with MISO model returning 0x3C, div=0 → MOSI bits 1,0,1,0,0,1,0,1 (MSB first); busy for 16 cycles; DATA read = 0x0000_003C.
- div=3 transfer → every SCK high and low phase is exactly 4 clk cycles; the total busy window is 64 cycles.
- DATA write 0x11 while busy → transmitted byte unchanged from the first write; CSR[30]=1; writing CSR with [30]=1 and [0]=1 clears overrun and keeps cs asserted.
- `wb_cyc` held high for 4 cycles → `wb_ack` pulses on cycles 1 and 3 only; `wb_rdata`=0 on non-ack cycles; reads at address 2 return 0.
- Assert `rst` mid-transfer (bit 4) → `spi_sck`=0 and `spi_cs_n`=1 immediately; after release, busy=0 and a new transfer completes normally.
